// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, diff = a - b - bin.
// One bit per clock, LSB first, single registered borrow, start/busy/done handshake.
// Operands are captured on the accepting edge; all outputs are registered.
module serial_subtractor #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_sh_reg;
  logic             br_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             a_msb_reg;
  logic             b_msb_reg;

  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  // One full-subtractor cell on the current LSBs; result bit enters at the MSB end
  always_comb begin
    d_bit    = a_sh_reg[0] ^ b_sh_reg[0] ^ br_reg;
    br_next  = (~a_sh_reg[0] & b_sh_reg[0]) | (~(a_sh_reg[0] ^ b_sh_reg[0]) & br_reg);
    res_next = {d_bit, res_sh_reg[WIDTH-1:1]};
  end

  // Control FSM plus datapath registers; results are published only when entering DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      br_reg     <= 1'b0;
      cnt_reg    <= '0;
      a_msb_reg  <= 1'b0;
      b_msb_reg  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      bout       <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            br_reg    <= bin;
            cnt_reg   <= '0;
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= b[WIDTH-1];
            busy      <= 1'b1;
            state_reg <= SHIFT;
          end else begin
            busy <= 1'b0;
          end
        end
        SHIFT: begin
          // start is deliberately ignored here so a running operation is never disturbed
          res_sh_reg <= res_next;
          br_reg     <= br_next;
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          cnt_reg    <= cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_CNT) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            diff      <= res_next;
            bout      <= br_next;
            // Sign rule: operands of opposite sign and a result whose sign differs from a
            overflow  <= (a_msb_reg != b_msb_reg) & (res_next[WIDTH-1] != a_msb_reg);
            zero      <= (res_next == '0);
            state_reg <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          // Back-to-back: a new request is accepted while the done pulse is showing
          if (start) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            br_reg    <= bin;
            cnt_reg   <= '0;
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= b[WIDTH-1];
            busy      <= 1'b1;
            state_reg <= SHIFT;
          end else begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
